// File: rtl/seg_digit_scanner.sv
// Time-multiplexed N-digit BCD scanner: snapshots inputs once per frame and
// drives one digit per prescaler slot, with leading-zero blanking and blink.
module seg_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blink_mask,
  input  logic                      blank_lz,
  output logic [3:0]                digit_out,
  output logic [NUM_DIGITS-1:0]     digit_sel,
  output logic                      dp_out,
  output logic                      blank_out,
  output logic                      frame_start
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0]         PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_MAX = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0]         BLK_MAX = BW'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_mask_q, sh_mask_d;
  logic                    sh_lz_q, sh_lz_d;
  logic                    sh_phase_q, sh_phase_d;
  logic [3:0]              digit_out_q, digit_out_d;
  logic [NUM_DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                    dp_out_q, dp_out_d;
  logic                    blank_out_q, blank_out_d;
  logic                    frame_start_q, frame_start_d;

  logic                    tick;
  logic                    frame_entry;
  logic [NUM_DIGITS-1:0]   zero_run;
  logic [3:0]              cur_digit;
  logic                    cur_dp;
  logic                    blanked;

  always_comb begin : scan_next
    tick          = en && (pre_q == PRE_MAX);
    frame_entry   = tick && (idx_q == IDX_MAX);
    pre_d         = pre_q;
    idx_d         = idx_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    sh_digits_d   = sh_digits_q;
    sh_dp_d       = sh_dp_q;
    sh_mask_d     = sh_mask_q;
    sh_lz_d       = sh_lz_q;
    sh_phase_d    = sh_phase_q;

    if (en) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
    end
    if (tick) begin
      idx_d = frame_entry ? '0 : idx_q + 1'b1;
    end
    // The phase in force when the frame starts is latched so every slot of
    // the frame blinks consistently.
    if (frame_entry) begin
      sh_digits_d = digits_in;
      sh_dp_d     = dp_in;
      sh_mask_d   = blink_mask;
      sh_lz_d     = blank_lz;
      sh_phase_d  = blink_phase_q;
      if (blink_cnt_q == BLK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin : display_next
    logic run;
    run      = 1'b1;
    zero_run = '0;
    // zero_run[i]: digits i..top are all zero with no decimal point set.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run         = run && (sh_digits_d[4*i +: 4] == 4'd0) && !sh_dp_d[i];
      zero_run[i] = run;
    end
    cur_digit = sh_digits_d[{idx_d, 2'b00} +: 4];
    cur_dp    = sh_dp_d[idx_d];
    blanked   = (sh_lz_d && (idx_d != '0) && zero_run[idx_d]) ||
                (sh_phase_d && sh_mask_d[idx_d]);

    digit_out_d   = digit_out_q;
    digit_sel_d   = digit_sel_q;
    dp_out_d      = dp_out_q;
    blank_out_d   = blank_out_q;
    frame_start_d = frame_entry;
    if (tick) begin
      if (blanked) begin
        digit_out_d = 4'd0;
        digit_sel_d = '0;
        dp_out_d    = 1'b0;
        blank_out_d = 1'b1;
      end else begin
        digit_out_d = cur_digit;
        digit_sel_d = SEL_ONE << idx_d;
        dp_out_d    = cur_dp;
        blank_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= IDX_MAX;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_mask_q     <= '0;
      sh_lz_q       <= 1'b0;
      sh_phase_q    <= 1'b0;
      digit_out_q   <= 4'd0;
      digit_sel_q   <= '0;
      dp_out_q      <= 1'b0;
      blank_out_q   <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_mask_q     <= sh_mask_d;
      sh_lz_q       <= sh_lz_d;
      sh_phase_q    <= sh_phase_d;
      digit_out_q   <= digit_out_d;
      digit_sel_q   <= digit_sel_d;
      dp_out_q      <= dp_out_d;
      blank_out_q   <= blank_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign digit_out   = digit_out_q;
  assign digit_sel   = digit_sel_q;
  assign dp_out      = dp_out_q;
  assign blank_out   = blank_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: randomized stimulus against a frame/slot model
// (4 digits, 3-cycle slots, 2-frame blink) plus a 3-digit, 1-cycle-slot instance.
module tb_seg_digit_scanner;
  localparam int N  = 4;
  localparam int SD = 3;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] digits_in;
  logic [3:0]  dp_in, blink_mask;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  digit_sel;
  logic        dp_out, blank_out, frame_start;

  logic        en3;
  logic [11:0] digits3;
  logic [3:0]  digit_out3;
  logic [2:0]  digit_sel3;
  logic        dp_out3, blank_out3, frame_start3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg_digit_scanner #(.NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
    .blink_mask(blink_mask), .blank_lz(blank_lz), .digit_out(digit_out),
    .digit_sel(digit_sel), .dp_out(dp_out), .blank_out(blank_out),
    .frame_start(frame_start)
  );

  seg_digit_scanner #(.NUM_DIGITS(3), .SCAN_DIV(1), .BLINK_FRAMES(1)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .digits_in(digits3), .dp_in(3'b000),
    .blink_mask(3'b000), .blank_lz(1'b0), .digit_out(digit_out3),
    .digit_sel(digit_sel3), .dp_out(dp_out3), .blank_out(blank_out3),
    .frame_start(frame_start3)
  );

  wire [10:0] obs = {digit_out, digit_sel, dp_out, blank_out, frame_start};
  localparam logic [10:0] RESET_VAL = {4'h0, 4'h0, 1'b0, 1'b1, 1'b0};

  // Model: count enabled cycles into slots; slot t (1-based) shows digit
  // (t-1)%N of frame (t-1)/N from the snapshot taken when that frame began.
  int          m_pre, m_ticks;
  logic [15:0] s_dig;
  logic [3:0]  s_dp, s_bm;
  logic        s_lz;
  logic [10:0] m_exp;

  task automatic model_edge();
    int  idx, frame;
    bit  lz, bl;
    m_exp[0] = 1'b0;
    if (en) begin
      m_pre++;
      if (m_pre == SD) begin
        m_pre = 0;
        m_ticks++;
        idx   = (m_ticks - 1) % N;
        frame = (m_ticks - 1) / N;
        if (idx == 0) begin
          s_dig = digits_in; s_dp = dp_in; s_bm = blink_mask; s_lz = blank_lz;
        end
        lz = 0;
        if (s_lz && idx > 0) begin
          lz = 1;
          for (int j = idx; j < N; j++)
            if (((s_dig >> (4 * j)) & 16'hF) != 0 || s_dp[j]) lz = 0;
        end
        bl = ((frame / BF) % 2 == 1) && s_bm[idx];
        if (lz || bl) m_exp = {4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
        else m_exp = {4'((s_dig >> (4 * idx)) & 16'hF), 4'(1 << idx), s_dp[idx], 1'b0, 1'b0};
        m_exp[0] = (idx == 0);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_pre = 0; m_ticks = 0; m_exp = RESET_VAL;
    s_dig = '0; s_dp = '0; s_bm = '0; s_lz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++)
      digits_in[4*i +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
    dp_in      = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
    blink_mask = 4'($urandom_range(0, 15));
    blank_lz   = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    en = 1'b1; digits_in = 16'h1234; dp_in = '0; blink_mask = '0; blank_lz = 1'b0;
    do_reset();
    n_cmp++;
    if (obs !== RESET_VAL) begin
      n_bad++; $display("FAIL reset_state got=%h want=%h", obs, RESET_VAL);
    end
    for (int k = 1; k <= 15; k++) begin
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL first_frame edge=%0d got=%h want=%h", k, obs, m_exp);
      end
      if (k == 3) begin
        n_cmp++;
        if ({digit_out, digit_sel, frame_start} !== {4'h4, 4'b0001, 1'b1}) begin
          n_bad++; $display("FAIL third_edge got=%h want=%h", {digit_out, digit_sel, frame_start}, 9'h083);
        end
      end
    end
  endtask

  task automatic test_snapshot();
    en = 1'b1; digits_in = 16'h1234; dp_in = '0; blink_mask = '0; blank_lz = 1'b0;
    do_reset();
    for (int k = 0; k < 36; k++) begin
      if (m_ticks == 2) digits_in = 16'h5678;
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL snapshot k=%0d got=%h want=%h", k, obs, m_exp);
      end
      if (m_ticks == 3 && m_pre == 0) begin
        n_cmp++;
        if (digit_out !== 4'h2) begin
          n_bad++; $display("FAIL no_tearing got=%h want=2", digit_out);
        end
      end
      if (m_ticks == 5 && m_pre == 0) begin
        n_cmp++;
        if (digit_out !== 4'h8) begin
          n_bad++; $display("FAIL new_frame got=%h want=8", digit_out);
        end
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] pat_d [3] = '{16'h0045, 16'h0000, 16'h0005};
    logic [3:0]  pat_p [3] = '{4'b0000, 4'b0000, 4'b0100};
    en = 1'b1; blink_mask = '0; blank_lz = 1'b1;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      digits_in = pat_d[p]; dp_in = pat_p[p];
      for (int k = 0; k < 24; k++) begin
        step();
        n_cmp++;
        if (obs !== m_exp) begin
          n_bad++; $display("FAIL lz_pattern p=%0d k=%0d got=%h want=%h", p, k, obs, m_exp);
        end
        if (s_dig == 16'h0045 && m_pre == 0 && (m_ticks - 1) % N == 2) begin
          n_cmp++;
          if ({digit_sel, blank_out} !== 5'b0000_1) begin
            n_bad++; $display("FAIL lz_0045_slot2 got=%b want=00001", {digit_sel, blank_out});
          end
        end
      end
    end
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) rand_inputs();
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL lz_random k=%0d got=%h want=%h", k, obs, m_exp);
      end
    end
  endtask

  task automatic test_blink();
    en = 1'b1; digits_in = 16'h1234; dp_in = 4'b0010; blink_mask = 4'b0001; blank_lz = 1'b0;
    do_reset();
    for (int k = 0; k < 6 * N * SD; k++) begin
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL blink k=%0d got=%h want=%h", k, obs, m_exp);
      end
      if (m_pre == 0 && m_ticks == 9) begin
        n_cmp++;
        if ({blank_out, digit_sel} !== 5'b1_0000) begin
          n_bad++; $display("FAIL blink_frame2 got=%b want=10000", {blank_out, digit_sel});
        end
      end
    end
  endtask

  task automatic test_freeze_and_reset();
    logic [10:0] held;
    en = 1'b1; digits_in = 16'h9876; dp_in = 4'b0001; blink_mask = '0; blank_lz = 1'b0;
    do_reset();
    for (int k = 0; k < 7; k++) step();
    held = m_exp;
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (obs !== {held[10:1], 1'b0}) begin
        n_bad++; $display("FAIL freeze k=%0d got=%h want=%h", k, obs, {held[10:1], 1'b0});
      end
    end
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL resume k=%0d got=%h want=%h", k, obs, m_exp);
      end
    end
    do_reset();
    n_cmp++;
    if (obs !== RESET_VAL) begin
      n_bad++; $display("FAIL mid_reset got=%h want=%h", obs, RESET_VAL);
    end
    digits_in = 16'h4321;
    for (int k = 0; k < 3; k++) step();
    n_cmp++;
    if ({digit_out, digit_sel, frame_start} !== {4'h1, 4'b0001, 1'b1}) begin
      n_bad++; $display("FAIL restart_slot0 got=%h want=%h", {digit_out, digit_sel, frame_start}, 9'h023);
    end
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 4) == 0) rand_inputs();
      en = ($urandom_range(0, 3) != 0);
      step();
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++; $display("FAIL random_en k=%0d got=%h want=%h", k, obs, m_exp);
      end
    end
  endtask

  task automatic test_fast();
    logic [3:0] want_d;
    en = 1'b0; en3 = 1'b1; digits3 = 12'h987;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      want_d = ((k - 1) % 3 == 0) ? 4'h7 : ((k - 1) % 3 == 1) ? 4'h8 : 4'h9;
      n_cmp++;
      if ({digit_out3, digit_sel3, blank_out3, frame_start3} !==
          {want_d, 3'(1 << ((k - 1) % 3)), 1'b0, 1'((k - 1) % 3 == 0)}) begin
        n_bad++;
        $display("FAIL fast_scan edge=%0d got=%h want=%h", k,
                 {digit_out3, digit_sel3, blank_out3, frame_start3},
                 {want_d, 3'(1 << ((k - 1) % 3)), 1'b0, 1'((k - 1) % 3 == 0)});
      end
    end
    en3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en3 = 1'b0; digits3 = '0;
    digits_in = '0; dp_in = '0; blink_mask = '0; blank_lz = 1'b0;
    test_reset();
    test_snapshot();
    test_lz();
    test_blink();
    test_freeze_and_reset();
    test_fast();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
